// File: rtl/router_pkg.sv
// Shared router definitions: packet width, arbiter state encoding and
// stall counter width used by the node-side load port logic.
package router_pkg;

    localparam int PKT_W       = 29;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around, found by rotating a doubled request vector.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  winner
);

    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    logic [ID_W-1:0]    off_s;
    logic [ID_W:0]      sum_s;

    // Rotate so ptr lands at bit 0, priority-encode, then undo the rotation.
    always_comb begin
        dbl_s = {req, req};
        rot_s = N_REQ'(dbl_s >> ptr);
        off_s = {ID_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? ID_W'(i) : off_s;
        end
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        if (sum_s >= (ID_W+1)'(N_REQ)) begin
            winner = ID_W'(sum_s - (ID_W+1)'(N_REQ));
        end else begin
            winner = sum_s[ID_W-1:0];
        end
        any = |req;
    end

endmodule

// File: rtl/node_port_arbiter.sv
// Shares the router core's node-side load port among N_REQ requesters with
// round-robin priority, a captured holding register and a sticky stall flag.
module node_port_arbiter #(
    parameter int   N_REQ       = 4,
    parameter int   PKT_W       = router_pkg::PKT_W,
    parameter int   STALL_LIMIT = 1024,
    localparam int  ID_W        = $clog2(N_REQ)
) (
    input  logic                   Clk_R,
    input  logic                   Rst,
    input  logic [N_REQ-1:0]       Req_Valid,
    input  logic [N_REQ*PKT_W-1:0] Req_Packet,
    output logic [N_REQ-1:0]       Req_Ack,
    output logic [PKT_W-1:0]       Packet_From_Node,
    output logic                   Packet_From_Node_Valid,
    input  logic                   Core_Load_Ack,
    output logic [ID_W-1:0]        Grant_Id,
    output logic                   Busy,
    output logic                   Stall_Err
);

    import router_pkg::*;

    arb_state_t             state_r;
    arb_state_t             next_state_s;
    logic [ID_W-1:0]        rr_ptr_r;
    logic [ID_W-1:0]        grant_r;
    logic [PKT_W-1:0]       pkt_r;
    logic                   valid_r;
    logic [N_REQ-1:0]       ack_r;
    logic                   busy_r;
    logic                   stall_r;
    logic [STALL_CNT_W-1:0] cnt_r;

    logic                   any_s;
    logic [ID_W-1:0]        winner_s;
    logic [PKT_W-1:0]       pkt_sel_s;
    logic                   load_s;
    logic                   done_s;
    logic [N_REQ-1:0]       ack_next_s;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req    (Req_Valid),
        .ptr    (rr_ptr_r),
        .any    (any_s),
        .winner (winner_s)
    );

    // Select the winning requester's packet slice.
    always_comb begin
        pkt_sel_s = {PKT_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            pkt_sel_s = (winner_s == ID_W'(i)) ? Req_Packet[i*PKT_W +: PKT_W] : pkt_sel_s;
        end
    end

    // State register.
    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; RELEASE always lasts exactly one cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (Core_Load_Ack) begin
                    next_state_s = RELEASE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            RELEASE: next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode: grant strobe, acceptance strobe and next acknowledge vector.
    always_comb begin
        load_s     = 1'b0;
        done_s     = 1'b0;
        ack_next_s = {N_REQ{1'b0}};
        case (state_r)
            IDLE: load_s = any_s;
            WAIT: begin
                done_s = Core_Load_Ack;
                if (Core_Load_Ack) begin
                    ack_next_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_r;
                end else begin
                    ack_next_s = {N_REQ{1'b0}};
                end
            end
            RELEASE: load_s = 1'b0;
            default: load_s = 1'b0;
        endcase
    end

    // Holding register, grant index, priority pointer and acknowledge outputs.
    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            pkt_r    <= {PKT_W{1'b0}};
            grant_r  <= {ID_W{1'b0}};
            rr_ptr_r <= {ID_W{1'b0}};
            valid_r  <= 1'b0;
            ack_r    <= {N_REQ{1'b0}};
            busy_r   <= 1'b0;
        end else begin
            if (load_s) begin
                pkt_r   <= pkt_sel_s;
                grant_r <= winner_s;
                valid_r <= 1'b1;
            end else if (done_s) begin
                valid_r  <= 1'b0;
                rr_ptr_r <= (grant_r == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : grant_r + ID_W'(1);
            end
            ack_r  <= ack_next_s;
            busy_r <= (next_state_s != IDLE);
        end
    end

    // Saturating stall counter and sticky stall flag; the transfer is never aborted.
    always_ff @(posedge Clk_R) begin
        if (Rst) begin
            cnt_r   <= {STALL_CNT_W{1'b0}};
            stall_r <= 1'b0;
        end else begin
            if (load_s) begin
                cnt_r <= {STALL_CNT_W{1'b0}};
            end else if (state_r == WAIT && cnt_r != {STALL_CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + STALL_CNT_W'(1);
            end
            if (state_r == WAIT && cnt_r == STALL_CNT_W'(STALL_LIMIT)) begin
                stall_r <= 1'b1;
            end
        end
    end

    assign Packet_From_Node       = pkt_r;
    assign Packet_From_Node_Valid = valid_r;
    assign Req_Ack                = ack_r;
    assign Grant_Id               = grant_r;
    assign Busy                   = busy_r;
    assign Stall_Err              = stall_r;

endmodule

// File: tb/tb_node_port_arbiter.sv
// Self-checking bench for node_port_arbiter: grant/packet scoreboard plus
// per-scenario tasks for timing, wrap-around, stall and reset behaviour.
module tb_node_port_arbiter;

    typedef struct packed {
        logic [1:0]  id;
        logic [28:0] pkt;
    } exp_t;

    logic         clk = 1'b0;
    logic         Rst;
    logic [3:0]   Req_Valid;
    logic [115:0] Req_Packet;
    logic [3:0]   Req_Ack;
    logic [28:0]  Packet_From_Node;
    logic         Packet_From_Node_Valid;
    logic         Core_Load_Ack;
    logic [1:0]   Grant_Id;
    logic         Busy;
    logic         Stall_Err;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   gen [4];
    exp_t exp_q [$];
    int   rise_q [$];
    exp_t e_m;
    logic [1:0] last_id = 2'd0;
    logic       prev_valid = 1'b0;
    logic [3:0] prev_ack = 4'd0;
    logic [3:0] exp_ack;

    node_port_arbiter #(
        .N_REQ       (4),
        .PKT_W       (29),
        .STALL_LIMIT (8)
    ) dut (
        .Clk_R                  (clk),
        .Rst                    (Rst),
        .Req_Valid              (Req_Valid),
        .Req_Packet             (Req_Packet),
        .Req_Ack                (Req_Ack),
        .Packet_From_Node       (Packet_From_Node),
        .Packet_From_Node_Valid (Packet_From_Node_Valid),
        .Core_Load_Ack          (Core_Load_Ack),
        .Grant_Id               (Grant_Id),
        .Busy                   (Busy),
        .Stall_Err              (Stall_Err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [28:0] pk(input int i, input int g);
        logic [31:0] t;
        t = 32'h0100_0000 * (i + 1) + 32'h0000_1111 * g + 32'h0000_005A;
        return t[28:0];
    endfunction

    // Scoreboard: each new transfer is popped and compared; each ack is checked.
    always @(negedge clk) begin
        if (Packet_From_Node_Valid && !prev_valid) begin
            rise_q.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got id=%0d pkt=%h want no transfer", Grant_Id, Packet_From_Node);
            end else begin
                e_m = exp_q.pop_front();
                last_id = e_m.id;
                if (Grant_Id !== e_m.id || Packet_From_Node !== e_m.pkt) begin
                    bad++;
                    $display("FAIL sb_grant: got id=%0d pkt=%h want id=%0d pkt=%h",
                             Grant_Id, Packet_From_Node, e_m.id, e_m.pkt);
                end
            end
        end
        if (Req_Ack !== 4'b0000) begin
            total++;
            exp_ack = 4'b0001 << last_id;
            if (Req_Ack !== exp_ack || prev_ack !== 4'b0000 || Packet_From_Node_Valid !== 1'b0) begin
                bad++;
                $display("FAIL sb_ack: got ack=%b prev=%b valid=%b want ack=%b prev=0000 valid=0",
                         Req_Ack, prev_ack, Packet_From_Node_Valid, exp_ack);
            end
        end
        prev_valid = Packet_From_Node_Valid;
        prev_ack   = Req_Ack;
    end

    task automatic set_pkts();
        for (int i = 0; i < 4; i++) Req_Packet[i*29 +: 29] = pk(i, gen[i]);
    endtask

    // Serve n transfers: core acks on the k-th valid cycle; requesters either
    // keep requesting with a fresh packet (cont) or drop after their ack.
    task automatic run(input int k, input bit cont, input int n, input int budget);
        int vcnt = 0;
        int done = 0;
        int used = 0;
        while (done < n && used < budget) begin
            @(negedge clk);
            used++;
            if (Req_Ack != 4'b0000) begin
                done++;
                for (int i = 0; i < 4; i++) begin
                    if (Req_Ack[i]) begin
                        if (cont) begin
                            gen[i]++;
                            Req_Packet[i*29 +: 29] = pk(i, gen[i]);
                        end else begin
                            Req_Valid[i] = 1'b0;
                        end
                    end
                end
            end
            if (Packet_From_Node_Valid) vcnt++;
            else vcnt = 0;
            Core_Load_Ack = Packet_From_Node_Valid && (vcnt == k);
        end
        Core_Load_Ack = 1'b0;
        total++;
        if (done < n) begin
            bad++;
            $display("FAIL run_timeout: got %0d acks want %0d", done, n);
        end
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!Packet_From_Node_Valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (Packet_From_Node_Valid !== 1'b1) begin
            bad++;
            $display("FAIL valid_timeout: got valid=%b want 1", Packet_From_Node_Valid);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Req_Valid = 4'b0000;
        Req_Packet = '0;
        Core_Load_Ack = 1'b0;
        for (int i = 0; i < 4; i++) gen[i] = 0;
        repeat (3) @(negedge clk);
        total += 6;
        if (Packet_From_Node_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", Packet_From_Node_Valid); end
        if (Packet_From_Node !== 29'd0) begin bad++; $display("FAIL rst_pkt: got %h want 0", Packet_From_Node); end
        if (Req_Ack !== 4'b0000) begin bad++; $display("FAIL rst_ack: got %b want 0000", Req_Ack); end
        if (Grant_Id !== 2'd0) begin bad++; $display("FAIL rst_grant: got %0d want 0", Grant_Id); end
        if (Busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", Busy); end
        if (Stall_Err !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", Stall_Err); end
        Rst = 1'b0;
    endtask

    task automatic test_idle_ack();
        Core_Load_Ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (Packet_From_Node_Valid !== 1'b0 || Req_Ack !== 4'b0000 || Busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_ack: got valid=%b ack=%b busy=%b want 0 0000 0",
                         Packet_From_Node_Valid, Req_Ack, Busy);
            end
        end
        Core_Load_Ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        repeat (2) @(negedge clk);
        rise_q.delete();
        set_pkts();
        exp_q.push_back('{id: 2'd0, pkt: pk(0, 0)});
        exp_q.push_back('{id: 2'd1, pkt: pk(1, 0)});
        exp_q.push_back('{id: 2'd2, pkt: pk(2, 0)});
        exp_q.push_back('{id: 2'd3, pkt: pk(3, 0)});
        exp_q.push_back('{id: 2'd0, pkt: pk(0, 1)});
        Req_Valid = 4'b1111;
        run(1, 1'b1, 5, 40);
        Req_Valid = 4'b0000;
        total++;
        if (rise_q.size() != 5) begin
            bad++;
            $display("FAIL b2b_rises: got %0d want 5", rise_q.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                total++;
                if (rise_q[i] - rise_q[i-1] != 3) begin
                    bad++;
                    $display("FAIL b2b_period: got %0d want 3", rise_q[i] - rise_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_single();
        repeat (2) @(negedge clk);
        set_pkts();
        Req_Packet[2*29 +: 29] = 29'h0ABCDEF;
        exp_q.push_back('{id: 2'd2, pkt: 29'h0ABCDEF});
        Req_Valid = 4'b0100;
        @(negedge clk);
        total += 3;
        if (Packet_From_Node_Valid !== 1'b1) begin bad++; $display("FAIL single_v1: got %b want 1", Packet_From_Node_Valid); end
        if (Packet_From_Node !== 29'h0ABCDEF) begin bad++; $display("FAIL single_pkt: got %h want 0abcdef", Packet_From_Node); end
        if (Grant_Id !== 2'd2) begin bad++; $display("FAIL single_grant: got %0d want 2", Grant_Id); end
        @(negedge clk);
        total++;
        if (Packet_From_Node_Valid !== 1'b1) begin bad++; $display("FAIL single_v2: got %b want 1", Packet_From_Node_Valid); end
        Core_Load_Ack = 1'b1;
        @(negedge clk);
        Core_Load_Ack = 1'b0;
        Req_Valid = 4'b0000;
        total += 3;
        if (Packet_From_Node_Valid !== 1'b0) begin bad++; $display("FAIL single_v3: got %b want 0", Packet_From_Node_Valid); end
        if (Req_Ack !== 4'b0100) begin bad++; $display("FAIL single_ack: got %b want 0100", Req_Ack); end
        if (Busy !== 1'b1) begin bad++; $display("FAIL single_busy_rel: got %b want 1", Busy); end
        @(negedge clk);
        total += 2;
        if (Req_Ack !== 4'b0000) begin bad++; $display("FAIL single_ack_end: got %b want 0000", Req_Ack); end
        if (Busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle: got %b want 0", Busy); end
    endtask

    task automatic test_wrap();
        repeat (2) @(negedge clk);
        set_pkts();
        exp_q.push_back('{id: 2'd0, pkt: pk(0, gen[0])});
        exp_q.push_back('{id: 2'd1, pkt: pk(1, gen[1])});
        Req_Valid = 4'b0011;
        run(1, 1'b0, 2, 30);
    endtask

    task automatic test_stall();
        logic [28:0] hold;
        repeat (2) @(negedge clk);
        set_pkts();
        hold = pk(0, gen[0]);
        exp_q.push_back('{id: 2'd0, pkt: hold});
        Req_Valid = 4'b0001;
        wait_valid();
        for (int v = 1; v <= 20; v++) begin
            if (v > 1) @(negedge clk);
            total++;
            if (Packet_From_Node_Valid !== 1'b1 || Packet_From_Node !== hold) begin
                bad++;
                $display("FAIL stall_hold v=%0d: got valid=%b pkt=%h want 1 %h", v, Packet_From_Node_Valid, Packet_From_Node, hold);
            end
            if (v <= 8) begin
                total++;
                if (Stall_Err !== 1'b0) begin bad++; $display("FAIL stall_early v=%0d: got %b want 0", v, Stall_Err); end
            end
            if (v >= 10) begin
                total++;
                if (Stall_Err !== 1'b1) begin bad++; $display("FAIL stall_set v=%0d: got %b want 1", v, Stall_Err); end
            end
            if (v == 20) Core_Load_Ack = 1'b1;
        end
        @(negedge clk);
        Core_Load_Ack = 1'b0;
        Req_Valid = 4'b0000;
        total += 2;
        if (Req_Ack !== 4'b0001) begin bad++; $display("FAIL stall_ack: got %b want 0001", Req_Ack); end
        if (Packet_From_Node_Valid !== 1'b0) begin bad++; $display("FAIL stall_done: got %b want 0", Packet_From_Node_Valid); end
        repeat (3) begin
            @(negedge clk);
            total++;
            if (Stall_Err !== 1'b1) begin bad++; $display("FAIL stall_sticky: got %b want 1", Stall_Err); end
        end
    endtask

    task automatic test_reset_in_wait();
        repeat (2) @(negedge clk);
        set_pkts();
        exp_q.push_back('{id: 2'd1, pkt: pk(1, gen[1])});
        Req_Valid = 4'b0010;
        wait_valid();
        @(negedge clk);
        Rst = 1'b1;
        @(negedge clk);
        total += 5;
        if (Packet_From_Node_Valid !== 1'b0) begin bad++; $display("FAIL rw_valid: got %b want 0", Packet_From_Node_Valid); end
        if (Req_Ack !== 4'b0000) begin bad++; $display("FAIL rw_ack: got %b want 0000", Req_Ack); end
        if (Busy !== 1'b0) begin bad++; $display("FAIL rw_busy: got %b want 0", Busy); end
        if (Stall_Err !== 1'b0) begin bad++; $display("FAIL rw_stall: got %b want 0", Stall_Err); end
        if (Grant_Id !== 2'd0) begin bad++; $display("FAIL rw_grant: got %0d want 0", Grant_Id); end
        Req_Valid = 4'b1001;
        Rst = 1'b0;
        exp_q.push_back('{id: 2'd0, pkt: pk(0, gen[0])});
        exp_q.push_back('{id: 2'd3, pkt: pk(3, gen[3])});
        run(2, 1'b0, 2, 30);
    endtask

    initial begin
        test_reset();
        test_idle_ack();
        test_back_to_back();
        test_single();
        test_wrap();
        test_stall();
        test_reset_in_wait();
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
